// File: rtl/add_pkg.sv
// Shared width and word type for the adder datapath.
package add_pkg;
  localparam int ADD_W = 4;
  typedef logic [ADD_W-1:0] add_word_t;
endpackage

// File: rtl/add_1b.sv
// One-bit full adder; the cell of the ripple chain in add_4b.
module add_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/add_4b.sv
// Ripple-carry adder with carry/overflow flags and a registered copy of all results.
module add_4b
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // Carry-in tied low; bit i only sees bits <= i, so an X stays above its source.
  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    add_1b u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign out  = s;
  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= out;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end
endmodule

// File: tb/tb_add_4b.sv
// Directed and exhaustive checks of add_4b combinational and registered outputs.
module tb_add_4b;
  logic       clk;
  logic       rst_n;
  logic [3:0] x, y;
  logic [3:0] out, sum_q;
  logic       cout, ovf, cout_q, ovf_q;

  int n_cmp = 0;
  int n_bad = 0;

  add_4b dut (
    .x      (x),
    .y      (y),
    .out    (out),
    .cout   (cout),
    .ovf    (ovf),
    .clk    (clk),
    .rst_n  (rst_n),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[6] = '{
    '{4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0},
    '{4'b1000, 4'b1001, 4'b0001, 1'b1, 1'b1},
    '{4'b1101, 4'b1001, 4'b0110, 1'b1, 1'b1},
    '{4'b1101, 4'b0110, 4'b0011, 1'b1, 1'b0},
    '{4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0},
    '{4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1}
  };

  initial begin
    rst_n = 1'b0;
    x = 4'd0;
    y = 4'd0;
    #2;
    chk("rst sum_q", 8'(sum_q), 8'h0);
    chk("rst cout_q", 8'(cout_q), 8'h0);
    chk("rst ovf_q", 8'(ovf_q), 8'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, each also checked one edge later on the registered path.
    foreach (vecs[k]) begin
      @(negedge clk);
      x = vecs[k].a;
      y = vecs[k].b;
      #1;
      chk($sformatf("vec%0d out", k), 8'(out), 8'(vecs[k].s));
      chk($sformatf("vec%0d cout", k), 8'(cout), 8'(vecs[k].co));
      chk($sformatf("vec%0d ovf", k), 8'(ovf), 8'(vecs[k].ov));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d sum_q", k), 8'(sum_q), 8'(vecs[k].s));
      chk($sformatf("vec%0d cout_q", k), 8'(cout_q), 8'(vecs[k].co));
      chk($sformatf("vec%0d ovf_q", k), 8'(ovf_q), 8'(vecs[k].ov));
    end

    // Exhaustive sweep against integer arithmetic.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [4:0] r;
        logic [3:0] a4, b4;
        logic       ev;
        a4 = 4'(i);
        b4 = 4'(j);
        r  = 5'(i + j);
        ev = (a4[3] == b4[3]) && (r[3] != a4[3]);
        x = a4;
        y = b4;
        #1;
        chk($sformatf("sweep %0d+%0d out", i, j), 8'(out), 8'(r[3:0]));
        chk($sformatf("sweep %0d+%0d cout", i, j), 8'(cout), 8'(r[4]));
        chk($sformatf("sweep %0d+%0d ovf", i, j), 8'(ovf), 8'(ev));
      end
    end

    // Load a non-zero registered value, then reset mid-cycle.
    @(negedge clk);
    x = 4'b1101;
    y = 4'b0110;
    @(posedge clk);
    #1;
    chk("pre-rst sum_q", 8'(sum_q), 8'h3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst sum_q", 8'(sum_q), 8'h0);
    chk("async rst cout_q", 8'(cout_q), 8'h0);
    chk("async rst ovf_q", 8'(ovf_q), 8'h0);
    chk("rst out", 8'(out), 8'h3);
    chk("rst cout", 8'(cout), 8'h1);
    @(posedge clk);
    #1;
    chk("rst held sum_q", 8'(sum_q), 8'h0);
    chk("rst held out", 8'(out), 8'h3);

    @(negedge clk);
    rst_n = 1'b1;
    x = 4'b1101;
    y = 4'b0110;
    #1;
    chk("post-rst pre-edge sum_q", 8'(sum_q), 8'h0);
    chk("post-rst out", 8'(out), 8'h3);
    @(posedge clk);
    #1;
    chk("post-rst sum_q", 8'(sum_q), 8'h3);
    chk("post-rst cout_q", 8'(cout_q), 8'h1);
    chk("post-rst ovf_q", 8'(ovf_q), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
